// File: rtl/fixed_divide.sv
// fixed_divide
//
// Iterative signed fixed-point divider, c = a / b. Both operands and the
// result share one two's-complement fixed-point format. One quotient bit is
// produced per clock using a restoring shift-subtract loop on magnitudes. The
// sign is applied and the range is checked at the end.
//
// Parameters
//   BITS       total word width of a, b and c
//   PRECISION  format string; its last two characters give the decimal
//              number of fraction bits (e.g. "FIXED_04_04" -> 4)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operands valid
//   in_ready     divider idle, operands accepted when in_valid is also high
//   a, b         dividend, divisor
//   out_valid    one-cycle pulse, c and flags valid
//   c            quotient
//   div_by_zero  result flag: divisor was zero
//   overflow     result flag: true quotient does not fit in BITS
//
// Build option
//   FIXED_DIVIDE_SATURATE_EN  when defined, overflow and divide-by-zero
//                             saturate c. Otherwise overflow wraps and
//                             divide-by-zero returns 0.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// BUSY  | shift-subtract iterations, one quotient bit per cycle
// DONE  | result presented for one cycle, out_valid high

module fixed_divide #(
    parameter int          BITS      = 8,
    parameter logic [87:0] PRECISION = "FIXED_04_04"
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [BITS-1:0] a,
    input  logic signed [BITS-1:0] b,
    output logic                   out_valid,
    output logic signed [BITS-1:0] c,
    output logic                   div_by_zero,
    output logic                   overflow
);

    localparam int FRACTION = 10 * (int'(PRECISION[15:8]) - 48)
                            + (int'(PRECISION[7:0]) - 48);
    localparam int N  = BITS + FRACTION;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0]   CNT_INIT  = CW'(N - 1);
    // Largest magnitudes that still fit for a negative / positive result.
    localparam logic [N-1:0]    Q_LIM_NEG = N'(1) << (BITS - 1);
    localparam logic [N-1:0]    Q_LIM_POS = Q_LIM_NEG - N'(1);
    localparam logic [BITS-1:0] SAT_POS   = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] SAT_NEG   = {1'b1, {(BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]   cnt;
    logic            sign;
    logic [BITS-1:0] b_mag;
    logic [N-1:0]    dq;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [BITS:0]   rem;

    logic            accept;
    logic [BITS-1:0] a_abs;
    logic [BITS-1:0] b_abs;
    logic [BITS:0]   rem_shift;
    logic [BITS+1:0] rem_diff;
    logic            ge;
    logic [BITS:0]   rem_nxt;
    logic [N-1:0]    dq_nxt;
    logic [BITS-1:0] q_low_signed;
    logic            fin_ovf;
    logic [BITS-1:0] fin_c;
    logic [BITS-1:0] dz_c;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (b == '0) ? DONE : BUSY;
            end
            BUSY: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && (state == IDLE);

    // ---------------- datapath ----------------
    always_comb begin
        // Negating the most negative value wraps back to itself, which read
        // as unsigned is exactly 2^(BITS-1), the correct magnitude.
        a_abs = a[BITS-1] ? (~a + 1'b1) : a;
        b_abs = b[BITS-1] ? (~b + 1'b1) : b;

        rem_shift = {rem[BITS-1:0], dq[N-1]};
        rem_diff  = {1'b0, rem_shift} - {2'b00, b_mag};
        // A set top remainder bit means the shifted value exceeds any divisor.
        ge        = rem[BITS] | ~rem_diff[BITS+1];
        rem_nxt   = ge ? rem_diff[BITS:0] : rem_shift;
        dq_nxt    = {dq[N-2:0], ge};

        // Low BITS of the negated magnitude equal the low BITS of the
        // full-width two's-complement result, so only those are formed.
        q_low_signed = sign ? (~dq_nxt[BITS-1:0] + 1'b1) : dq_nxt[BITS-1:0];
        fin_ovf      = sign ? (dq_nxt > Q_LIM_NEG) : (dq_nxt > Q_LIM_POS);
`ifdef FIXED_DIVIDE_SATURATE_EN
        fin_c = fin_ovf ? (sign ? SAT_NEG : SAT_POS) : q_low_signed;
        dz_c  = a[BITS-1] ? SAT_NEG : SAT_POS;
`else
        fin_c = q_low_signed;
        dz_c  = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            sign        <= 1'b0;
            b_mag       <= '0;
            dq          <= '0;
            rem         <= '0;
            c           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                sign  <= a[BITS-1] ^ b[BITS-1];
                b_mag <= b_abs;
                dq    <= N'(a_abs) << FRACTION;
                rem   <= '0;
                if (b == '0) begin
                    // No iterations: result is registered now so it is
                    // valid during the DONE cycle that follows.
                    cnt         <= '0;
                    c           <= dz_c;
                    div_by_zero <= 1'b1;
                    overflow    <= 1'b0;
                end else begin
                    cnt <= CNT_INIT;
                end
            end else if (state == BUSY) begin
                rem <= rem_nxt;
                dq  <= dq_nxt;
                if (cnt == '0) begin
                    // Last quotient bit: register the finished result so it
                    // is presented in DONE.
                    c           <= fin_c;
                    overflow    <= fin_ovf;
                    div_by_zero <= 1'b0;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_divide.sv
// tb_fixed_divide
//
// Directed bench for fixed_divide at BITS=8, PRECISION="FIXED_04_04".
// Expected quotients are hand-computed; saturating expectations follow
// FIXED_DIVIDE_SATURATE_EN so the bench serves both builds.

module tb_fixed_divide;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic [7:0] c;
    logic       div_by_zero;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FIXED_DIVIDE_SATURATE_EN
    localparam logic [7:0] OVF_POS_C = 8'h7F;
    localparam logic [7:0] DZ_POS_C  = 8'h7F;
    localparam logic [7:0] DZ_NEG_C  = 8'h80;
`else
    localparam logic [7:0] OVF_POS_C = 8'h00;
    localparam logic [7:0] DZ_POS_C  = 8'h00;
    localparam logic [7:0] DZ_NEG_C  = 8'h00;
`endif

    fixed_divide #(
        .BITS      (8),
        .PRECISION ("FIXED_04_04")
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .c           (c),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after an accepting edge. Counts falling edges until
    // out_valid is seen; in_ready must stay low the whole time.
    task automatic wait_result(input string tag, output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check({tag, "_rdy_low"}, in_ready, 1'b0);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] exp_c, input logic exp_dz, input logic exp_ovf,
                           input int exp_lat);
        int lat;
        @(negedge clk);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        check({tag, "_rdy"}, in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(tag, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_c"}, c, exp_c);
        check({tag, "_dz"}, div_by_zero, exp_dz);
        check({tag, "_ovf"}, overflow, exp_ovf);
        @(negedge clk);
        check({tag, "_pulse"}, out_valid, 1'b0);
        check({tag, "_rdy_back"}, in_ready, 1'b1);
    endtask

    initial begin
        int lat;
        bit seen;

        repeat (2) @(negedge clk);
        check("rst_rdy", in_ready, 1'b1);
        check("rst_ov", out_valid, 1'b0);
        check("rst_c", c, 8'h00);
        check("rst_dz", div_by_zero, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;

        run_div("basic",   8'h30, 8'h20, 8'h18, 1'b0, 1'b0, 13);
        run_div("neg_a",   8'hD0, 8'h20, 8'hE8, 1'b0, 1'b0, 13);
        run_div("third",   8'h10, 8'h30, 8'h05, 1'b0, 1'b0, 13);
        run_div("ntrunc",  8'hF0, 8'h30, 8'hFB, 1'b0, 1'b0, 13);
        run_div("maxpos",  8'h7F, 8'h10, 8'h7F, 1'b0, 1'b0, 13);
        run_div("negneg",  8'hE0, 8'hF0, 8'h20, 1'b0, 1'b0, 13);
        run_div("ovf",     8'h70, 8'h01, OVF_POS_C, 1'b0, 1'b1, 13);
        run_div("minneg",  8'h80, 8'h10, 8'h80, 1'b0, 1'b0, 13);
        run_div("dz_pos",  8'h10, 8'h00, DZ_POS_C, 1'b1, 1'b0, 1);
        run_div("dz_neg",  8'hF0, 8'h00, DZ_NEG_C, 1'b1, 1'b0, 1);

        // in_valid held high, operands changed while busy
        @(negedge clk);
        a        = 8'h30;
        b        = 8'h20;
        in_valid = 1'b1;
        check("hs_rdy", in_ready, 1'b1);
        @(posedge clk);
        #1;
        a = 8'h10;
        b = 8'h30;
        wait_result("hs1", lat);
        check("hs1_lat", lat, 13);
        check("hs1_c", c, 8'h18);
        @(negedge clk);
        check("hs_idle_rdy", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result("hs2", lat);
        check("hs2_lat", lat, 13);
        check("hs2_c", c, 8'h05);
        @(negedge clk);

        // reset 5 cycles into an operation
        @(negedge clk);
        a        = 8'h30;
        b        = 8'h20;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_rdy", in_ready, 1'b1);
        check("mrst_ov", out_valid, 1'b0);
        check("mrst_c", c, 8'h00);
        check("mrst_dz", div_by_zero, 1'b0);
        check("mrst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mrst_no_ov", seen, 1'b0);
        run_div("after_rst", 8'hF0, 8'h30, 8'hFB, 1'b0, 1'b0, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_divide.md
# fixed_divide

Iterative signed fixed-point divider. Computes c = a / b for two's-complement operands in the same fixed-point format, one bit of quotient per cycle. It sits directly upstream of the integer-part stage in the fixed-point precision chain. Its c/out_valid outputs connect straight to that stage's a/in_valid inputs, so floor-style division is divider followed by integer-part extraction.

## Interface
- BITS, default 8: total word width of a, b, c.
- PRECISION, default "FIXED_04_04": format string. Last two characters are the decimal fraction-bit count: FRACTION = 10*(PRECISION[15:8]-8'h30) + (PRECISION[7:0]-8'h30). Requires 0 <= FRACTION < BITS.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider idle and able to accept.
- a  input  signed [BITS-1:0]  dividend.
- b  input  signed [BITS-1:0]  divisor.
- out_valid  output  1  one-cycle pulse, c valid.
- c  output  signed [BITS-1:0]  quotient, same format.
- div_by_zero  output  1  qualifies current result; b was 0.
- overflow  output  1  qualifies current result; true quotient outside BITS range.

## Operation
- States: IDLE, BUSY, DONE.
- in_ready = (state == IDLE), combinational from state.
- Accept when in_valid && in_ready:
  - Latch sign = a[BITS-1] ^ b[BITS-1].
  - Latch |a| and |b| as BITS-bit unsigned values; |-2^(BITS-1)| = 2^(BITS-1) is exact.
  - Dividend register = |a| << FRACTION, width BITS+FRACTION.
- b == 0 at accept: go directly to DONE with div_by_zero = 1. No iterations run.
- Otherwise enter BUSY with the iteration counter at BITS+FRACTION-1.
- BUSY runs a restoring shift-subtract loop, one quotient bit per cycle, MSB first:
  - Remainder width BITS+1.
  - Counter decrements each cycle.
  - At counter == 0, go to DONE.
- DONE is held for exactly one cycle:
  - out_valid = 1.
  - The final magnitude q (BITS+FRACTION bits, truncated toward zero) is signed and range-checked.
  - Next state is IDLE.
- Range check: overflow = 1 if q > 2^(BITS-1)-1 with sign 0, or q > 2^(BITS-1) with sign 1.
- Result when there is no overflow: c = sign ? -q : q.
- Overflow and div_by_zero handling depend on the configuration macro (see Configuration).
- c, div_by_zero and overflow are registered. They hold their value until the next DONE and are meaningful only while out_valid is high.
- in_valid is ignored while in BUSY or DONE. There is no queueing; upstream must hold or retry.
- No backpressure on the output: the downstream stage is combinational and always accepts.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, c 0, div_by_zero 0, overflow 0, counter 0.
- Normal latency: out_valid rises BITS+FRACTION+1 rising edges after the accepting edge. That is 13 edges for BITS=8, FRACTION=4.
- Divide-by-zero latency: out_valid is high on the cycle after the accepting edge.
- Throughput: one division per BITS+FRACTION+2 cycles. in_ready returns high on the cycle after out_valid.
- Reset asserted mid-BUSY or in DONE: all outputs return immediately to their reset values and the operation is discarded. No out_valid is produced for it.
- Back-to-back: in_valid held high from the start yields a new accept on the first IDLE cycle after each DONE.

## Configuration
- FIXED_DIVIDE_SATURATE_EN, defined:
  - Overflow gives c = 0x7F..F (max positive) when sign is 0, or 0x80..0 (min negative) when sign is 1.
  - Divide by zero gives c = max positive if a >= 0, min negative if a < 0.
- FIXED_DIVIDE_SATURATE_EN, undefined:
  - Overflow gives c = low BITS bits of the two's-complement signed q (wrap).
  - Divide by zero gives c = 0.
- Both flags are reported identically in either build.

## Test plan
All scenarios use BITS=8, PRECISION="FIXED_04_04".
- Basic: a=0x30 (3.0), b=0x20 (2.0) accepted at edge N -> out_valid at edge N+13, c=0x18 (1.5), both flags 0.
- Sign and truncation:
  - a=0xD0 (-3.0), b=0x20 -> c=0xE8.
  - a=0x10, b=0x30 -> c=0x05.
  - a=0xF0, b=0x30 -> c=0xFB (truncation toward zero).
- Overflow: a=0x70 (7.0), b=0x01 (0.0625).
  - With macro: c=0x7F, overflow=1.
  - Without macro: c=0x00, overflow=1.
  - a=0x80, b=0x10 -> c=0x80, overflow=0.
- Divide by zero: a=0x10, b=0x00 -> out_valid one cycle after accept, div_by_zero=1.
  - With macro: c=0x7F.
  - Without macro: c=0x00.
- Handshake:
  - in_valid held high with changing operands during BUSY -> only the first operand pair is processed.
  - in_ready is low from the edge after accept through DONE.
- Reset mid-operation: rst_n pulsed low 5 cycles after accept -> out_valid never pulses for that operation, in_ready=1 and c=0 immediately, the next division completes correctly.
